seg_scan_6: RTL and testbench

SEG_SCAN_6 -- requirements
Module: seg_scan_6

---
 rtl/seg_scan_6.sv | 107 ++++++++++
 tb/tb_seg_scan_6.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_6.sv
// Six-digit multiplexed seven-segment scanner for an HH:MM:SS clock display.
// A frame snapshot keeps the digits stable while they are being scanned.
module seg_scan_6 #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_bcd,
    input  logic        sec_tick,
    input  logic        blank_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'd5;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   snap;
    logic          blink;

    logic          slot_end;
    logic          frame_wrap;
    logic [3:0]    nib;
    logic [6:0]    seg_next;
    logic [5:0]    an_next;
    logic          dp_next;

    assign slot_end   = (cnt == CNT_MAX);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    always_comb begin
        nib = 4'd0;
        case (idx)
            3'd0:    nib = snap[3:0];
            3'd1:    nib = snap[7:4];
            3'd2:    nib = snap[11:8];
            3'd3:    nib = snap[15:12];
            3'd4:    nib = snap[19:16];
            3'd5:    nib = snap[23:20];
            default: nib = 4'd0;
        endcase
    end

    // Non-BCD nibbles show a dash; a zero tens-of-hours digit may be blanked.
    always_comb begin
        seg_next = 7'h3F;
        case (nib)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h3F;
        endcase
        if (blank_en && (idx == IDX_LAST) && (nib == 4'd0)) begin
            seg_next = 7'h7F;
        end
    end

    // The first count of each slot drives all anodes off to avoid ghosting.
    always_comb begin
        an_next = 6'h3F;
        if (cnt != '0) begin
            an_next = ~(6'b000001 << idx);
        end
        dp_next = !(((idx == 3'd2) || (idx == 3'd4)) && blink);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= 3'd0;
            snap       <= 24'h000000;
            blink      <= 1'b0;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= 6'h3F;
            frame_done <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end
            if (frame_wrap) begin
                snap <= time_bcd;
            end
            if (sec_tick) begin
                blink <= ~blink;
            end
            frame_done <= frame_wrap;
            seg        <= seg_next;
            an         <= an_next;
            dp         <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_6.sv
// Bench for seg_scan_6 with SCAN_DIV=4: per-cycle reference model feeding an
// expected queue, table-driven digit vectors, and hand-written corner sequences.
module tb_seg_scan_6;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] time_bcd = 24'h0;
    logic        sec_tick = 1'b0;
    logic        blank_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    seg_scan_6 #(.SCAN_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .time_bcd(time_bcd), .sec_tick(sec_tick),
        .blank_en(blank_en), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model; packed expectation is {seg, dp, an, frame_done}.
    localparam logic [14:0] RST_OBS = {7'h7F, 1'b1, 6'h3F, 1'b0};
    logic [14:0] exp_q[$];
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [23:0] m_snap = 24'h0;
    logic        m_blink = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt   <= 0;
            m_idx   <= 0;
            m_snap  <= 24'h0;
            m_blink <= 1'b0;
            exp_q.delete();
            exp_q.push_back(RST_OBS);
        end else begin
            logic [3:0] n;
            logic [6:0] e_seg;
            logic [5:0] e_an;
            n = m_snap[m_idx*4 +: 4];
            e_seg = (blank_en && m_idx == 5 && n == 4'd0) ? 7'h7F : dec(n);
            e_an = (m_cnt == 0) ? 6'h3F : ~(6'b000001 << m_idx);
            exp_q.push_back({e_seg, !((m_idx == 2 || m_idx == 4) && m_blink), e_an,
                             (m_cnt == DIV - 1 && m_idx == 5)});
            m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
            if (m_cnt == DIV - 1) m_idx <= (m_idx == 5) ? 0 : m_idx + 1;
            if (m_cnt == DIV - 1 && m_idx == 5) m_snap <= time_bcd;
            if (sec_tick) m_blink <= ~m_blink;
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [14:0] e;
            e = exp_q.pop_front();
            check("scoreboard", {17'h0, seg, dp, an, frame_done}, {17'h0, e});
        end
    end

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        if (n >= 200) check("wait_fd_timeout", 1, 0);
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        logic [5:0] want;
        want = ~(6'b000001 << s);
        do begin
            @(negedge clk);
            n++;
        end while (an !== want && n < 200);
        if (n >= 200) check("wait_slot_timeout", 1, 0);
    endtask

    typedef struct {
        logic [23:0] bcd;
        logic        blank;
        int          slot;
        logic [6:0]  exp_seg;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        int errs;
        logic [6:0] s0;
        logic [6:0] s5;

        vecs[0] = '{24'h235947, 1'b0, 0, 7'h78};
        vecs[1] = '{24'h235947, 1'b0, 2, 7'h10};
        vecs[2] = '{24'h235947, 1'b0, 5, 7'h24};
        vecs[3] = '{24'h091530, 1'b1, 5, 7'h7F};
        vecs[4] = '{24'h091530, 1'b0, 5, 7'h40};
        vecs[5] = '{24'h091530, 1'b1, 4, 7'h10};
        vecs[6] = '{24'h0000C0, 1'b0, 1, 7'h3F};
        vecs[7] = '{24'h00000F, 1'b0, 0, 7'h3F};
        vecs[8] = '{24'h800000, 1'b1, 5, 7'h00};
        vecs[9] = '{24'h111111, 1'b0, 3, 7'h79};

        // Reset state, then first frame must show zeros with frame_done at cycle 24.
        repeat (3) @(negedge clk);
        check("reset_seg", {25'h0, seg}, 32'h7F);
        check("reset_an", {26'h0, an}, 32'h3F);
        check("reset_dp_fd", {30'h0, dp, frame_done}, 32'h2);
        time_bcd = 24'h235947;
        rst = 1'b1;
        n = 0;
        s0 = 7'h55;
        s5 = 7'h55;
        do begin
            @(negedge clk);
            n++;
            if (an === 6'b111110) s0 = seg;
            if (an === 6'b011111) s5 = seg;
        end while (frame_done !== 1'b1 && n < 100);
        check("first_fd_cycle", n, 24);
        check("first_frame_slot0", {25'h0, s0}, 32'h40);
        check("first_frame_slot5", {25'h0, s5}, 32'h40);

        // Scan pattern over one frame: one guard-blank cycle then three lit cycles per slot.
        errs = 0;
        for (int k = 1; k <= 24; k++) begin
            logic [5:0] w;
            @(negedge clk);
            w = (((k - 1) % 4) == 0) ? 6'h3F : ~(6'b000001 << ((k - 1) / 4));
            if (an !== w) errs++;
        end
        check("scan_pattern_errs", errs, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            time_bcd = vecs[i].bcd;
            blank_en = vecs[i].blank;
            wait_fd();
            wait_slot(vecs[i].slot);
            check($sformatf("vec%0d_seg", i), {25'h0, seg}, {25'h0, vecs[i].exp_seg});
        end
        blank_en = 1'b0;

        // Mid-frame input change must not disturb the frame being shown.
        time_bcd = 24'h000000;
        wait_fd();
        wait_slot(2);
        time_bcd = 24'h111111;
        wait_slot(4);
        check("midframe_hold", {25'h0, seg}, 32'h40);
        wait_fd();
        wait_slot(0);
        check("next_frame_ones", {25'h0, seg}, 32'h79);

        // Blink: dp low on slots 2 and 4 only between the two pulses.
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        wait_slot(2);
        check("blink_on_slot2", {31'h0, dp}, 32'h0);
        wait_slot(3);
        check("blink_on_slot3", {31'h0, dp}, 32'h1);
        wait_slot(4);
        check("blink_on_slot4", {31'h0, dp}, 32'h0);
        wait_slot(0);
        check("blink_on_slot0", {31'h0, dp}, 32'h1);
        repeat (100 - 30) @(negedge clk);
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        wait_slot(2);
        check("blink_off_slot2", {31'h0, dp}, 32'h1);

        // sec_tick on the wrap edge: both blink toggle and snapshot load.
        n = 0;
        while (!(m_cnt == DIV - 1 && m_idx == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wrap_align_timeout", (n >= 100) ? 1 : 0, 0);
        time_bcd = 24'h222222;
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        check("wrap_fd", {31'h0, frame_done}, 32'h1);
        wait_slot(2);
        check("wrap_blink_dp", {31'h0, dp}, 32'h0);
        check("wrap_snap_seg", {25'h0, seg}, 32'h24);

        // Asynchronous reset between edges in slot 3.
        wait_slot(3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_seg", {25'h0, seg}, 32'h7F);
        check("async_rst_an", {26'h0, an}, 32'h3F);
        check("async_rst_dp_fd", {30'h0, dp, frame_done}, 32'h2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an === 6'h3F && n < 50);
        check("restart_slot0", {26'h0, an}, 32'h3E);
        check("restart_latency", n, 2);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
